// File: rtl/encode.sv
// Kyber ByteEncode_l: packs 4 coeffs/beat (l bits each) into 64-bit words; a word is valid 1 cycle after 64 bits are buffered.
// Input stalls when the buffer holds >=80 bits or the frame's 64 beats are in; o_obytes is held while the sink stalls.
module encode #(
    parameter int NCOEFF = 256,
    parameter int CW     = 12,
    parameter int BUFW   = 128
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic [3:0]      i_l,
    input  logic [4*CW-1:0] i_coeffs,
    input  logic            i_coeffs_valid,
    output logic            o_coeffs_ready,
    output logic [63:0]     o_obytes,
    output logic            o_obytes_valid,
    input  logic            i_obytes_ready,
    output logic            o_done
);

    localparam logic [6:0] BEATS = 7'(NCOEFF / 4);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic             init_q;
    logic [3:0]       l_q;
    logic [BUFW-1:0]  acc_q;
    logic [7:0]       buf_cnt;
    logic [6:0]       beat_cnt;
    logic [5:0]       word_cnt;

    logic [3:0]       l_in;
    logic [3:0]       l_eff;
    logic [CW-1:0]    mask;
    logic [4*CW-1:0]  pack_bits;
    logic             accept;
    logic             hs;
    logic             load;
    logic             last_word;
    logic [BUFW-1:0]  acc_sh;
    logic [BUFW-1:0]  acc_nxt;
    logic [7:0]       base;
    logic [7:0]       add_bits;
    logic [7:0]       cnt_nxt;

    assign o_coeffs_ready = init_q && (state != S_DONE) && (beat_cnt < BEATS) && (buf_cnt < 8'd80);

    always_comb begin
        l_in      = (i_l == 4'd0 || i_l > 4'd12) ? 4'd12 : i_l;
        l_eff     = (state == S_IDLE) ? l_in : l_q;
        mask      = ~({CW{1'b1}} << l_eff);
        pack_bits = '0;
        // Masked coeffs are abutted at multiples of l, earliest coeff in the LSBs.
        for (int n = 0; n < 4; n++) begin
            pack_bits = pack_bits | ((4*CW)'(i_coeffs[n*CW +: CW] & mask) << (n * int'(l_eff)));
        end
        accept    = i_coeffs_valid && o_coeffs_ready;
        hs        = o_obytes_valid && i_obytes_ready;
        load      = (buf_cnt >= 8'd64) && (!o_obytes_valid || i_obytes_ready);
        acc_sh    = load ? (acc_q >> 64) : acc_q;
        base      = load ? (buf_cnt - 8'd64) : buf_cnt;
        add_bits  = {2'b00, l_eff, 2'b00};
        acc_nxt   = accept ? (acc_sh | (BUFW'(pack_bits) << base)) : acc_sh;
        cnt_nxt   = accept ? (base + add_bits) : base;
        last_word = hs && (state == S_RUN) && (word_cnt == (6'({l_q, 2'b00}) - 6'd1));
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state          <= S_IDLE;
            init_q         <= 1'b0;
            l_q            <= 4'd12;
            acc_q          <= '0;
            buf_cnt        <= '0;
            beat_cnt       <= '0;
            word_cnt       <= '0;
            o_obytes       <= '0;
            o_obytes_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            acc_q   <= acc_nxt;
            buf_cnt <= cnt_nxt;
            o_done  <= 1'b0;
            if (load) begin
                o_obytes       <= acc_q[63:0];
                o_obytes_valid <= 1'b1;
            end else if (hs) begin
                o_obytes_valid <= 1'b0;
            end
            if (accept) beat_cnt <= beat_cnt + 7'd1;
            if (hs)     word_cnt <= word_cnt + 6'd1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        l_q   <= l_in;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_word) begin
                        state    <= S_DONE;
                        o_done   <= 1'b1;
                        beat_cnt <= '0;
                        word_cnt <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encode.sv
// Directed bench for encode: bit-level reference packing, sink stalls, input gaps, reset mid-frame.
module tb_encode;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [3:0]  i_l = 4'd12;
    logic [47:0] i_coeffs = '0;
    logic        i_coeffs_valid = 1'b0;
    logic        o_coeffs_ready;
    logic [63:0] o_obytes;
    logic        o_obytes_valid;
    logic        i_obytes_ready = 1'b1;
    logic        o_done;

    encode dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_l            (i_l),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_coeffs_ready (o_coeffs_ready),
        .o_obytes       (o_obytes),
        .o_obytes_valid (o_obytes_valid),
        .i_obytes_ready (i_obytes_ready),
        .o_done         (o_done)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    logic [11:0] cf [256];
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    int stall_bad, stall_seen, done_cnt, done_cyc, last_hs_cyc, acc_cnt;
    bit timed_out;

    // Reference packing: b[i*l+j] = bit j of coeff i, cut into 64-bit words.
    task automatic build_exp(input int l);
        logic [3071:0] bs;
        bs = '0;
        exp_q.delete();
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < l; j++)
                bs[i*l + j] = cf[i][j];
        for (int w = 0; w < 4*l; w++)
            exp_q.push_back(bs[64*w +: 64]);
    endtask

    // Drives one frame on falling edges and samples handshakes 1ns later.
    task automatic run_frame(input logic [3:0] l, input int vmode, input int rmode,
                             input int chg_l, input int max_words);
        bit last_acc, prev_stall;
        logic [63:0] prev_word;
        got_q.delete();
        stall_bad = 0; stall_seen = 0; done_cnt = 0; acc_cnt = 0;
        done_cyc = -1; last_hs_cyc = -1; timed_out = 1;
        last_acc = 0; prev_stall = 0; prev_word = '0;
        i_l = l;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge i_clk);
            if (chg_l >= 0 && acc_cnt > 0) i_l = 4'(chg_l);
            if (acc_cnt >= 64)
                i_coeffs_valid = 1'b0;
            else if (!(i_coeffs_valid && !last_acc))
                i_coeffs_valid = (vmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc_cnt < 64)
                i_coeffs = {cf[4*acc_cnt+3], cf[4*acc_cnt+2], cf[4*acc_cnt+1], cf[4*acc_cnt]};
            i_obytes_ready = (rmode != 0) ? (cyc % 3 == 0) : 1'b1;
            #1;
            last_acc = i_coeffs_valid && o_coeffs_ready;
            if (last_acc) acc_cnt++;
            if (prev_stall && (!o_obytes_valid || o_obytes !== prev_word)) stall_bad++;
            prev_stall = o_obytes_valid && !i_obytes_ready;
            if (prev_stall) stall_seen++;
            prev_word = o_obytes;
            if (o_obytes_valid && i_obytes_ready) begin
                got_q.push_back(o_obytes);
                last_hs_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
                timed_out = 0;
                break;
            end
            if (max_words > 0 && got_q.size() >= max_words) begin
                timed_out = 0;
                break;
            end
        end
        i_coeffs_valid = 1'b0;
        i_obytes_ready = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        checks++; if (o_obytes !== 64'h0) begin errors++; $display("FAIL rst_obytes: got %h expected 0", o_obytes); end
        checks++; if (o_obytes_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_obytes_valid); end
        checks++; if (o_coeffs_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", o_coeffs_ready); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", o_done); end
        @(negedge i_clk);
        i_rstn = 1'b1;
        #1;
        checks++; if (o_coeffs_ready !== 1'b0) begin errors++; $display("FAIL rdy_before_edge: got %b expected 0", o_coeffs_ready); end
        @(negedge i_clk);
        #1;
        checks++; if (o_coeffs_ready !== 1'b1) begin errors++; $display("FAIL rdy_after_edge: got %b expected 1", o_coeffs_ready); end
    endtask

    task automatic test_l12_ramp();
        for (int i = 0; i < 256; i++) cf[i] = 12'(i);
        build_exp(12);
        run_frame(4'd12, 0, 0, -1, 0);
        checks++; if (timed_out) begin errors++; $display("FAIL l12_timeout: got no o_done expected o_done"); end
        checks++; if (got_q.size() != 48) begin errors++; $display("FAIL l12_count: got %0d expected 48", got_q.size()); end
        checks++; if (got_q.size() < 1 || got_q[0] !== 64'h5004003002001000) begin
            errors++; $display("FAIL l12_word0: got %h expected 5004003002001000", (got_q.size() > 0) ? got_q[0] : 64'hx);
        end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL l12_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
        checks++; if (done_cyc != last_hs_cyc + 1) begin errors++; $display("FAIL l12_done_timing: got cycle %0d expected %0d", done_cyc, last_hs_cyc + 1); end
    endtask

    task automatic test_l1_alt();
        for (int i = 0; i < 256; i++) cf[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
        run_frame(4'd1, 0, 0, -1, 0);
        checks++; if (got_q.size() != 4) begin errors++; $display("FAIL l1_count: got %0d expected 4", got_q.size()); end
        for (int w = 0; w < got_q.size(); w++) begin
            checks++; if (got_q[w] !== 64'h5555555555555555) begin errors++; $display("FAIL l1_word[%0d]: got %h expected 5555555555555555", w, got_q[w]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l1_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_l10_stall();
        for (int i = 0; i < 256; i++) cf[i] = 12'($urandom);
        build_exp(10);
        run_frame(4'd10, 0, 1, -1, 0);
        checks++; if (got_q.size() != 40) begin errors++; $display("FAIL l10_count: got %0d expected 40", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL l10_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
        checks++; if (stall_seen == 0 || stall_bad != 0) begin
            errors++; $display("FAIL l10_stall_hold: got %0d unstable of %0d stalls expected 0 unstable, >0 stalls", stall_bad, stall_seen);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l10_done: got %0d pulses expected 1", done_cnt); end
    endtask

    task automatic test_l5_gaps();
        for (int i = 0; i < 256; i++) cf[i] = 12'($urandom);
        build_exp(5);
        run_frame(4'd5, 1, 0, -1, 0);
        checks++; if (acc_cnt != 64) begin errors++; $display("FAIL l5_beats: got %0d expected 64", acc_cnt); end
        checks++; if (got_q.size() != 20) begin errors++; $display("FAIL l5_count: got %0d expected 20", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL l5_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
    endtask

    task automatic test_l_sampling();
        for (int i = 0; i < 256; i++) cf[i] = 12'($urandom);
        build_exp(12);
        run_frame(4'd0, 0, 0, -1, 0);
        checks++; if (got_q.size() != 48) begin errors++; $display("FAIL l0_count: got %0d expected 48", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL l0_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
        build_exp(3);
        run_frame(4'd3, 0, 0, 9, 0);
        checks++; if (got_q.size() != 12) begin errors++; $display("FAIL lchg_count: got %0d expected 12", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL lchg_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 256; i++) cf[i] = 12'($urandom);
        build_exp(11);
        run_frame(4'd11, 0, 0, -1, 20);
        checks++; if (got_q.size() != 20 || got_q[19] !== exp_q[19]) begin
            errors++; $display("FAIL l11_partial: got %0d words expected 20 matching", got_q.size());
        end
        #2;
        i_rstn = 1'b0;
        #1;
        checks++; if (o_obytes !== 64'h0 || o_obytes_valid !== 1'b0 || o_coeffs_ready !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got obytes=%h vld=%b rdy=%b done=%b expected all 0",
                               o_obytes, o_obytes_valid, o_coeffs_ready, o_done);
        end
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 256; i++) cf[i] = 12'($urandom);
        build_exp(4);
        run_frame(4'd4, 0, 0, -1, 0);
        checks++; if (got_q.size() != 16) begin errors++; $display("FAIL l4_count: got %0d expected 16", got_q.size()); end
        for (int w = 0; w < got_q.size() && w < exp_q.size(); w++) begin
            checks++; if (got_q[w] !== exp_q[w]) begin errors++; $display("FAIL l4_word[%0d]: got %h expected %h", w, got_q[w], exp_q[w]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL l4_done: got %0d pulses expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_l12_ramp();
        test_l1_alt();
        test_l10_stall();
        test_l5_gaps();
        test_l_sampling();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
